// File: rtl/bus_pkg.sv
// Shared constants and types for the bus register file.
// Provides default sizes and the bus source-select encoding.
package bus_pkg;

  localparam int BUS_N_DEF    = 16;
  localparam int BUS_NREG_DEF = 8;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_G    = 2'd1,
    SRC_DIN  = 2'd2,
    SRC_REG  = 2'd3
  } src_e;

endpackage

// File: rtl/bus_regfile_if.sv
// Bus-side signal bundle of the register file.
// The master modport drives the selects and data, and the slave modport is the register file.
interface bus_regfile_if
  import bus_pkg::*;
#(
  parameter int N    = BUS_N_DEF,
  parameter int NREG = BUS_NREG_DEF
) ();

  logic [N-1:0]    Din;
  logic [N-1:0]    Gout;
  logic [NREG-1:0] rout;
  logic            gsel;
  logic            dinsel;
  logic [NREG-1:0] rin;
  logic            incr_pc;
  logic            err_clr;
  logic [N-1:0]    bus;
  logic [N-1:0]    pc;
  logic            bus_err;

  modport master (
    output Din, Gout, rout, gsel, dinsel, rin, incr_pc, err_clr,
    input  bus, pc, bus_err
  );

  modport slave (
    input  Din, Gout, rout, gsel, dinsel, rin, incr_pc, err_clr,
    output bus, pc, bus_err
  );

endinterface

// File: rtl/bus_regfile_pc_reg.sv
// Program counter: a bus load takes precedence over increment, which takes precedence over hold.
// The counter wraps modulo 2^N and has a synchronous active-low reset.
module pc_reg #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         incr_i,
  input  logic [N-1:0] din_i,
  output logic [N-1:0] pc_o
);

  logic [N-1:0] pc_d;
  logic [N-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = din_i;
    end else if (incr_i) begin
      pc_d = pc_q + {{(N-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/bus_regfile.sv
// Register file with a shared, priority-muxed bus; R[NREG-1] is the program counter.
// Define BUS_CONFLICT_CHK_EN to enable the sticky multi-source conflict flag on bus_err.
module bus_regfile
  import bus_pkg::*;
#(
  parameter int N    = BUS_N_DEF,
  parameter int NREG = BUS_NREG_DEF
) (
  input  logic          Clock,
  input  logic          Resetn,
  bus_regfile_if.slave  bif
);

  localparam int IW = $clog2(NREG);

  src_e            src_s;
  logic [IW-1:0]   ridx_s;
  logic [N-1:0]    bus_s;
  logic [N-1:0]    pc_s;
  logic [N-1:0]    rd_s   [NREG];
  logic [N-1:0]    regs_d [NREG-1];
  logic [N-1:0]    regs_q [NREG-1];

  always_comb begin
    for (int i = 0; i < NREG - 1; i++) begin
      rd_s[i] = regs_q[i];
    end
    rd_s[NREG-1] = pc_s;
  end

  // The descending scan leaves the lowest-index set bit of rout in ridx_s.
  always_comb begin
    ridx_s = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      ridx_s = bif.rout[i] ? IW'(i) : ridx_s;
    end
    if (bif.gsel) begin
      src_s = SRC_G;
    end else if (bif.dinsel) begin
      src_s = SRC_DIN;
    end else if (|bif.rout) begin
      src_s = SRC_REG;
    end else begin
      src_s = SRC_NONE;
    end
  end

  always_comb begin
    case (src_s)
      SRC_G:   bus_s = bif.Gout;
      SRC_DIN: bus_s = bif.Din;
      SRC_REG: bus_s = rd_s[ridx_s];
      default: bus_s = '0;
    endcase
  end

  // A register that is both source and target reloads its own value, so it holds.
  always_comb begin
    for (int i = 0; i < NREG - 1; i++) begin
      regs_d[i] = bif.rin[i] ? bus_s : regs_q[i];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  pc_reg #(.N(N)) u_pc (
    .clk    (Clock),
    .rst_n  (Resetn),
    .load_i (bif.rin[NREG-1]),
    .incr_i (bif.incr_pc),
    .din_i  (bus_s),
    .pc_o   (pc_s)
  );

  assign bif.bus = bus_s;
  assign bif.pc  = pc_s;

`ifdef BUS_CONFLICT_CHK_EN
  logic [NREG+1:0] sel_vec_s;
  logic            conflict_s;
  logic            err_d;
  logic            err_q;

  // Clearing the lowest set bit leaves a nonzero value only when two or more sources are asserted.
  assign sel_vec_s  = {bif.gsel, bif.dinsel, bif.rout};
  assign conflict_s = |(sel_vec_s & (sel_vec_s - {{(NREG+1){1'b0}}, 1'b1}));

  always_comb begin
    if (conflict_s) begin
      err_d = 1'b1;
    end else if (bif.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bif.bus_err = err_q;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = bif.err_clr;
  assign bif.bus_err      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_regfile.sv
// Self-checking bench for bus_regfile (N=16, NREG=8): directed steps followed by random traffic,
// all compared against a behavioural model of the register file.
module tb_bus_regfile;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  logic [15:0] m_reg [8];
  logic        m_err;

  bus_regfile_if #(.N(16), .NREG(8)) bif ();

  bus_regfile #(.N(16), .NREG(8)) dut (
    .Clock  (clk),
    .Resetn (resetn),
    .bif    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_bus();
    if (bif.gsel) return bif.Gout;
    if (bif.dinsel) return bif.Din;
    for (int i = 0; i < 8; i++) begin
      if (bif.rout[i]) return m_reg[i];
    end
    return 16'h0000;
  endfunction

  task automatic model_edge(input logic [15:0] b);
    int nsrc;
    nsrc = $countones({bif.gsel, bif.dinsel, bif.rout});
    if (!resetn) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_err = 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (bif.rin[i]) m_reg[i] = b;
      end
      if (bif.rin[7]) m_reg[7] = b;
      else if (bif.incr_pc) m_reg[7] = m_reg[7] + 16'd1;
`ifdef BUS_CONFLICT_CHK_EN
      if (nsrc > 1) m_err = 1'b1;
      else if (bif.err_clr) m_err = 1'b0;
`endif
    end
  endtask

  // One clock: check the combinational bus, advance the model, then check the registered outputs.
  task automatic step();
    logic [15:0] eb;
    #1;
    eb = model_bus();
    chk("bus", bif.bus, eb);
    @(posedge clk);
    model_edge(eb);
    #1;
    chk("pc", bif.pc, m_reg[7]);
    chk("bus_err", {15'd0, bif.bus_err}, {15'd0, m_err});
  endtask

  task automatic idle();
    resetn      = 1'b1;
    bif.Din     = 16'h0000;
    bif.Gout    = 16'h0000;
    bif.rout    = 8'h00;
    bif.gsel    = 1'b0;
    bif.dinsel  = 1'b0;
    bif.rin     = 8'h00;
    bif.incr_pc = 1'b0;
    bif.err_clr = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) begin
      idle();
      bif.rout = 8'(1 << i);
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_err    = 1'b0;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'hxxxx;

    // Reset while every register is being loaded and the PC incremented.
    idle();
    resetn      = 1'b0;
    bif.rin     = 8'hFF;
    bif.incr_pc = 1'b1;
    step();
    chk("reset_pc", bif.pc, 16'h0000);
    chk("reset_err", {15'd0, bif.bus_err}, 16'h0000);
    read_all();

    // Load R1 from Din, then move R1 to R4.
    idle();
    bif.dinsel = 1'b1;
    bif.Din    = 16'hA5A5;
    bif.rin    = 8'h02;
    step();
    idle();
    bif.rout = 8'h02;
    bif.rin  = 8'h10;
    #1 chk("move_bus", bif.bus, 16'hA5A5);
    step();
    idle();
    bif.rout = 8'h10;
    #1 chk("r4_bus", bif.bus, 16'hA5A5);
    step();

    // Gout beats Din, and the two together are a conflict.
    idle();
    bif.gsel   = 1'b1;
    bif.Gout   = 16'h1234;
    bif.dinsel = 1'b1;
    bif.Din    = 16'h5678;
    #1 chk("prio_bus", bif.bus, 16'h1234);
    step();

    // Sticky flag across idle cycles, then clear, then a clear that loses to a new conflict.
    for (int i = 0; i < 5; i++) begin
      idle();
      step();
    end
    idle();
    bif.err_clr = 1'b1;
    step();
    idle();
    bif.rout    = 8'h03;
    bif.err_clr = 1'b1;
    step();
    idle();
    step();
    idle();
    bif.err_clr = 1'b1;
    step();

    // PC wrap from all-ones, then a load that overrides a simultaneous increment.
    idle();
    bif.dinsel = 1'b1;
    bif.Din    = 16'hFFFF;
    bif.rin    = 8'h80;
    step();
    idle();
    bif.incr_pc = 1'b1;
    step();
    chk("pc_wrap", bif.pc, 16'h0000);
    idle();
    bif.dinsel  = 1'b1;
    bif.Din     = 16'h0040;
    bif.rin     = 8'h80;
    bif.incr_pc = 1'b1;
    step();
    chk("pc_load", bif.pc, 16'h0040);

    // Register both source and target keeps its value.
    idle();
    bif.rout = 8'h02;
    bif.rin  = 8'h02;
    step();

    // No source selected drives zero, which then loads into R0.
    idle();
    bif.rin = 8'h01;
    #1 chk("nosrc_bus", bif.bus, 16'h0000);
    step();
    read_all();

    // Randomized traffic with occasional mid-operation resets.
    for (int n = 0; n < 400; n++) begin
      int r;
      idle();
      resetn      = ($urandom_range(0, 39) != 0);
      bif.Din     = 16'($urandom);
      bif.Gout    = 16'($urandom);
      bif.gsel    = ($urandom_range(0, 7) == 0);
      bif.dinsel  = ($urandom_range(0, 3) == 0);
      r           = $urandom_range(0, 9);
      bif.rout    = (r < 8) ? 8'(1 << r) : ((r == 8) ? 8'h00 : 8'($urandom));
      bif.rin     = 8'($urandom) & 8'($urandom);
      bif.incr_pc = 1'($urandom);
      bif.err_clr = ($urandom_range(0, 3) == 0);
      step();
    end
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
